mr1_instr_fetch_bridge: RTL



---
 rtl/mr1_fetch_pkg.sv | 18 +
 rtl/mr1_fetch_cmd_reg.sv | 31 +++
 rtl/mr1_instr_fetch_bridge.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mr1_fetch_pkg.sv
// Shared definitions for the MR1 fetch-side bridges: error word, control states
// and the alignment helper.
package mr1_fetch_pkg;

    // All-zero word is an illegal instruction in RV32I, so MR1 traps on it.
    localparam logic [31:0] ERR_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        ERR_RSP = 2'd2
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mr1_fetch_cmd_reg.sv
// Valid/ready register slice: holds one command stable until the consumer takes it,
// and can reload in the same cycle the held command leaves.
module mr1_fetch_cmd_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData
);

    assign inReady = !outValid || outReady;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outValid <= 1'b0;
            outData  <= '0;
        end else if (inValid && inReady) begin
            outValid <= 1'b1;
            outData  <= inData;
        end else if (outReady) begin
            outValid <= 1'b0;
        end
    end

endmodule

// File: rtl/mr1_instr_fetch_bridge.sv
// MR1 instruction-fetch bridge: bounded, in-order fetches to a pipelined backend;
// misaligned and bus-error fetches are answered with an illegal-instruction word.
module mr1_instr_fetch_bridge
    import mr1_fetch_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] ERR_INSTR       = ERR_INSTR_DEFAULT,
    parameter bit          RESET_PC_CHECK  = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_req_valid,
    output logic        instr_req_ready,
    input  logic [31:0] instr_req_addr,
    output logic        instr_rsp_valid,
    output logic [31:0] instr_rsp_data,
    output logic        mem_cmd_valid,
    input  logic        mem_cmd_ready,
    output logic [31:0] mem_cmd_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_error,
    output logic [2:0]  outstanding,
    output logic        sticky_err
);

    localparam logic [3:0] MAX_COUNT = 4'(MAX_OUTSTANDING);

    fetch_state_e state;
    fetch_state_e stateNext;
    logic         runEn;
    logic [2:0]   countQ;
    logic [3:0]   countSum;
    logic         countBad;
    logic [2:0]   countNext;
    logic         cmdInReady;
    logic         reqMisaligned;
    logic         errPend;
    logic         accept;
    logic         acceptAligned;
    logic         acceptMisaligned;
    logic [2:0]   pendingRsp;
    logic         rspSolicited;
    logic         rspUnsolicited;
    logic         rspValidQ;
    logic [31:0]  rspDataQ;
    logic         stickyQ;

    assign reqMisaligned = is_misaligned(instr_req_addr);
    assign errPend       = (state == ERR_RSP);

    // A misaligned fetch is answered locally, so it may only go when nothing is in flight.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        instr_req_ready = runEn && !errPend && ({1'b0, countQ} < MAX_COUNT) && cmdInReady;
        if (reqMisaligned && ((countQ != 3'd0) || mem_cmd_valid)) begin
            instr_req_ready = 1'b0;
        end
    end

    assign accept           = instr_req_valid && instr_req_ready;
    assign acceptAligned    = accept && !reqMisaligned;
    assign acceptMisaligned = accept && reqMisaligned;

    mr1_fetch_cmd_reg #(
        .WIDTH(32)
    ) uCmdReg (
        .clk      (clk),
        .reset_n  (reset_n),
        .inValid  (acceptAligned),
        .inReady  (cmdInReady),
        .inData   ({instr_req_addr[31:2], 2'b00}),
        .outValid (mem_cmd_valid),
        .outReady (mem_cmd_ready),
        .outData  (mem_cmd_addr)
    );

    // A response already sitting in the output register is still counted, so exclude it.
    assign pendingRsp     = countQ - {2'b00, rspValidQ};
    assign rspSolicited   = mem_rsp_valid && (pendingRsp != 3'd0);
    assign rspUnsolicited = mem_rsp_valid && (pendingRsp == 3'd0);

    // Underflow wraps to 4'hF, so a single compare catches both directions.
    assign countSum  = {1'b0, countQ} + {3'b000, accept} - {3'b000, rspValidQ};
    assign countBad  = countSum > MAX_COUNT;
    assign countNext = countBad ? countQ : countSum[2:0];

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (acceptMisaligned) begin
                    stateNext = ERR_RSP;
                end else if (countNext != 3'd0) begin
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                if (countNext == 3'd0) begin
                    stateNext = IDLE;
                end
            end
            ERR_RSP: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // runEn keeps the request side closed until the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            runEn   <= 1'b0;
            countQ  <= 3'd0;
            stickyQ <= 1'b0;
        end else begin
            state   <= stateNext;
            runEn   <= 1'b1;
            countQ  <= countNext;
            stickyQ <= stickyQ || rspUnsolicited || (RESET_PC_CHECK && countBad);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rspValidQ <= 1'b0;
            rspDataQ  <= 32'h0000_0000;
        end else begin
            rspValidQ <= acceptMisaligned || rspSolicited;
            if (acceptMisaligned) begin
                rspDataQ <= ERR_INSTR;
            end else if (rspSolicited) begin
                rspDataQ <= mem_rsp_error ? ERR_INSTR : mem_rsp_data;
            end
        end
    end

    assign instr_rsp_valid = rspValidQ;
    assign instr_rsp_data  = rspDataQ;
    assign outstanding     = countQ;
    assign sticky_err      = stickyQ;

endmodule
